afifo_rd_stream: RTL and testbench
==================================

// Module: afifo_rd_stream
// PURPOSE
//  Read-side drain engine for the afifo read port; sits in the read-clock domain.
//  - Pops words from the FIFO (ren/empty/rd_data).
//  - Presents them as a valid/ready stream through a 2-entry prefetch buffer.
//  - Sustains 1 beat/cycle while the FIFO has data and the consumer is ready.
//  - Hides the FIFO read latency from the consumer.
// PARAMETERS
//  C_WIDTH   32  data width; must equal the afifo C_WIDTH
//  C_RD_LAT  1   afifo read latency: 0 = rd_data valid in the ren cycle; 1 = valid the cycle after ren
// PORTS
//  i_clk          in   1        read clock (same clock as the afifo i_rclk)
//  i_rst_n        in   1        asynchronous active-low reset
//  i_fifo_empty   in   1        afifo o_empty
//  i_fifo_data    in   C_WIDTH  afifo o_rd_data
//  o_fifo_ren     out  1        afifo i_ren
//  i_flush        in   1        synchronous flush: drop buffered and in-flight words
//  o_valid        out  1        stream word available
//  i_ready        in   1        consumer accepts the word
//  o_data         out  C_WIDTH  stream word (head of buffer)
//  o_rd_count     out  32       beats delivered (only with AFIFO_RD_CNT_EN)
// BEHAVIOUR
//  - Reset (async assert, sync release): buffer occupancy occ=0, inflight=0, o_valid=0,
//    o_data=0, o_rd_count=0. o_fifo_ren=0 while i_rst_n=0.
//  - Buffer FSM on occ:
//    - EMPTY->ONE on push.
//    - ONE->TWO on push without pop; ONE->EMPTY on pop without push; push+pop stays ONE.
//    - TWO->ONE on pop; push without pop in TWO is illegal and must never occur.
//  - pop = o_valid & i_ready.
//  - push = arrival of a FIFO word:
//    - C_RD_LAT=0: the o_fifo_ren cycle.
//    - C_RD_LAT=1: the cycle after o_fifo_ren; inflight register (0/1) tracks it.
//  - o_valid = (occ!=0). o_data = head entry, stable while o_valid & !i_ready.
//  - o_fifo_ren = !i_fifo_empty & !i_flush & (occ + inflight - pop < 2). Combinational from
//    registers and inputs; never asserted while i_fifo_empty=1.
//  - Latency: FIFO non-empty at cycle t, buffer empty:
//    - o_valid=1 at t+1 when C_RD_LAT=0.
//    - o_valid=1 at t+2 when C_RD_LAT=1.
//  - Throughput: back-to-back beats with C_RD_LAT=1 and i_ready held high.
//    Steady state is occ=1, inflight=1, ren every cycle.
//  - Consumer stall: at most 2 words are read ahead. No word is lost or duplicated.
//    Order is strictly FIFO.
//  - Simultaneous push and pop with occ=1: head advances, new word becomes tail/head correctly.
//  - i_flush=1: next cycle occ=0, o_valid=0, inflight=0. A word arriving from an in-flight
//    read in the flush cycle or the cycle after is discarded.
//  - A pop in the flush cycle still counts as delivered.
//  - Reset mid-operation: state clears immediately. Any FIFO word already popped is lost
//    by design; the afifo is reset alongside.
// CONFIGURATION
//  - AFIFO_RD_CNT_EN defined:
//    - o_rd_count increments on every pop and wraps 2^32-1 -> 0.
//    - i_flush does not clear it; only reset does.
//  - AFIFO_RD_CNT_EN undefined: o_rd_count port and counter absent. All other behaviour is identical.
// TESTING
//  1. Reset: i_rst_n=0, i_fifo_empty=0 -> o_fifo_ren=0, o_valid=0, o_data=0.
//     Release -> first ren the next cycle.
//  2. Single word, C_RD_LAT=1: FIFO holds 0xDEADBEEF, i_ready=1 -> ren 1 cycle.
//     o_valid=1 with o_data=0xDEADBEEF 2 cycles after empty drops; held 1 cycle.
//  3. Streaming: 16 words 0..15, i_ready=1 -> 16 consecutive beats 0..15, no gaps after first.
//     o_rd_count=16 with macro.
//  4. Stall: i_ready=0 for 10 cycles with 8 words queued -> exactly 2 ren pulses, o_data=0 stable.
//     After release, words 0..7 in order.
//  5. Flush: 1 buffered + 1 in-flight, i_flush=1 for 1 cycle -> o_valid=0 next cycle.
//     Neither word ever appears; next FIFO word is delivered normally.
//  6. Throughput check, C_RD_LAT=0, random i_ready (50%), 1000 words -> scoreboard exact order.
//     ren never asserted with empty=1; occ never exceeds 2.

Source files
------------

// File: rtl/afifo_rd_stream.sv
// Drains the afifo read port into a 2-entry prefetch buffer and presents the words as a
// valid/ready stream. Define AFIFO_RD_CNT_EN to add the o_rd_count delivered-beat counter.
module afifo_rd_stream #(
  parameter int unsigned C_WIDTH  = 32,
  parameter int unsigned C_RD_LAT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_fifo_empty,
  input  logic [C_WIDTH-1:0] i_fifo_data,
  output logic               o_fifo_ren,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [C_WIDTH-1:0] o_data
`ifdef AFIFO_RD_CNT_EN
  ,
  output logic [31:0]        o_rd_count
`endif
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } occ_e;

  occ_e               occ_q, occ_d;
  logic               inflight_q, inflight_d;
  logic [C_WIDTH-1:0] head_q, head_d;
  logic [C_WIDTH-1:0] tail_q, tail_d;
  logic               pop;
  logic               push;
  logic [1:0]         committed;

  assign o_valid = (occ_q != StEmpty);
  assign o_data  = head_q;
  assign pop     = o_valid & i_ready;

  // Words still owed to the consumer once this cycle's pop leaves; never exceeds 2.
  assign committed  = 2'(occ_q) + {1'b0, inflight_q} - {1'b0, pop};
  assign o_fifo_ren = i_rst_n & ~i_fifo_empty & ~i_flush & (committed < 2'd2);

  if (C_RD_LAT == 0) begin : g_lat0
    assign push       = o_fifo_ren;
    assign inflight_d = 1'b0;
  end else begin : g_lat1
    // A word landing during a flush belongs to the dropped stream.
    assign push       = inflight_q & ~i_flush;
    assign inflight_d = o_fifo_ren;
  end

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      StEmpty: begin
        if (push) begin
          occ_d  = StOne;
          head_d = i_fifo_data;
        end
      end
      StOne: begin
        if (push && !pop) begin
          occ_d  = StTwo;
          tail_d = i_fifo_data;
        end else if (!push && pop) begin
          occ_d = StEmpty;
        end else if (push && pop) begin
          head_d = i_fifo_data;
        end
      end
      StTwo: begin
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = i_fifo_data;
          end else begin
            occ_d = StOne;
          end
        end
      end
      default: occ_d = StEmpty;
    endcase
    if (i_flush) begin
      occ_d = StEmpty;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      occ_q      <= StEmpty;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

`ifdef AFIFO_RD_CNT_EN
  logic [31:0] rd_count_q, rd_count_d;

  // Pops during a flush still count; wraps naturally at 2^32.
  always_comb begin
    rd_count_d = rd_count_q;
    if (pop) begin
      rd_count_d = rd_count_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
    end
  end

  assign o_rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Bench for afifo_rd_stream: one instance per read latency, fed from a queue-based afifo
// model, with a read-order scoreboard plus a table of cycle-exact vectors.
module tb_afifo_rd_stream;
  localparam int unsigned W = 32;
  localparam int Depth = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         flush;
  logic         ready;
  logic         fifo_empty [2];
  logic [W-1:0] fifo_data  [2];
  logic         ren        [2];
  logic         valid      [2];
  logic [W-1:0] data       [2];
`ifdef AFIFO_RD_CNT_EN
  logic [31:0]  rd_count   [2];
`endif

  afifo_rd_stream #(.C_WIDTH(W), .C_RD_LAT(0)) u_lat0 (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_fifo_empty(fifo_empty[0]),
    .i_fifo_data (fifo_data[0]),
    .o_fifo_ren  (ren[0]),
    .i_flush     (flush),
    .o_valid     (valid[0]),
    .i_ready     (ready),
    .o_data      (data[0])
`ifdef AFIFO_RD_CNT_EN
    ,
    .o_rd_count  (rd_count[0])
`endif
  );

  afifo_rd_stream #(.C_WIDTH(W), .C_RD_LAT(1)) u_lat1 (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_fifo_empty(fifo_empty[1]),
    .i_fifo_data (fifo_data[1]),
    .o_fifo_ren  (ren[1]),
    .i_flush     (flush),
    .o_valid     (valid[1]),
    .i_ready     (ready),
    .o_data      (data[1])
`ifdef AFIFO_RD_CNT_EN
    ,
    .o_rd_count  (rd_count[1])
`endif
  );

  // afifo contents and the words read out but not yet delivered, per channel
  logic [W-1:0] fmem [2][Depth];
  int           fhead [2];
  int           ftail [2];
  logic [W-1:0] rmem [2][Depth];
  int           rhead [2];
  int           rtail [2];

  int checks = 0;
  int errors = 0;
  int delivered [2];
  int ren_cnt   [2];

  logic         s_ren   [2];
  logic         s_valid [2];
  logic         s_pop   [2];
  logic [W-1:0] s_data  [2];
  logic         prev_stall [2];
  logic [W-1:0] prev_data  [2];

  typedef struct {
    logic         push;
    logic [W-1:0] word;
    logic         rdy;
    logic         fl;
    logic [1:0]   exp_ren;
    logic [1:0]   exp_valid;
    logic [W-1:0] exp_d0;
    logic [W-1:0] exp_d1;
  } vec_t;

  vec_t vt [17];

  function automatic void chk(string name, int ch, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d: got %h expected %h", name, ch, act, exp);
    end
  endfunction

  function automatic void refresh();
    for (int c = 0; c < 2; c++) fifo_empty[c] = (fhead[c] == ftail[c]);
    fifo_data[0] = (fhead[0] != ftail[0]) ? fmem[0][fhead[0]] : '0;
  endfunction

  function automatic void push_word(logic [W-1:0] w);
    for (int c = 0; c < 2; c++) begin
      fmem[c][ftail[c]] = w;
      ftail[c]++;
    end
    refresh();
  endfunction

  // Sample outputs mid-cycle and run the invariant / order checks.
  task automatic settle();
    #1;
    for (int c = 0; c < 2; c++) begin
      s_ren[c]   = ren[c];
      s_valid[c] = valid[c];
      s_data[c]  = data[c];
      s_pop[c]   = valid[c] & ready;
      if (s_ren[c]) chk("ren_while_empty", c, 32'(fifo_empty[c]), 32'd0);
      if (s_valid[c]) begin
        chk("valid_has_word", c, 32'(rtail[c] > rhead[c]), 32'd1);
        if (prev_stall[c]) chk("stall_data_stable", c, s_data[c], prev_data[c]);
      end
      if (s_pop[c]) chk("pop_order", c, s_data[c], rmem[c][rhead[c]]);
      prev_stall[c] = s_valid[c] & ~ready;
      prev_data[c]  = s_data[c];
    end
  endtask

  // Cross the clock edge and update the afifo model and scoreboard.
  task automatic advance();
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        rhead[c]      = rtail[c];
        delivered[c]  = 0;
        prev_stall[c] = 1'b0;
      end else begin
        if (s_pop[c] && rhead[c] < rtail[c]) begin
          rhead[c]++;
          delivered[c]++;
        end
        if (flush) rhead[c] = rtail[c];
        if (s_ren[c] && fhead[c] != ftail[c]) begin
          rmem[c][rtail[c]] = fmem[c][fhead[c]];
          if (c == 1) fifo_data[1] = fmem[c][fhead[c]];
          fhead[c]++;
          rtail[c]++;
          ren_cnt[c]++;
        end
        chk("readahead_le2", c, 32'(rtail[c] - rhead[c] <= 2), 32'd1);
      end
    end
    refresh();
    @(negedge clk);
  endtask

  initial begin
    int base [2];
    int rbase [2];
    int beats [2];
    int pushed;

    rst_n = 1'b0;
    flush = 1'b0;
    ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      fhead[c] = 0; ftail[c] = 0; rhead[c] = 0; rtail[c] = 0;
      delivered[c] = 0; ren_cnt[c] = 0; prev_stall[c] = 1'b0; prev_data[c] = '0;
    end
    fifo_data[1] = '0;
    refresh();

    vt[0]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0};
    vt[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b01, 32'hDEADBEEF, 32'h0};
    vt[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b10, 32'h0, 32'hDEADBEEF};
    vt[3]  = '{1'b1, 32'h11,       1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0};
    vt[4]  = '{1'b1, 32'h22,       1'b0, 1'b0, 2'b11, 2'b01, 32'h11, 32'h0};
    vt[5]  = '{1'b1, 32'h33,       1'b0, 1'b0, 2'b00, 2'b11, 32'h11, 32'h11};
    vt[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 2'b11, 2'b11, 32'h11, 32'h11};
    vt[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b11, 32'h22, 32'h22};
    vt[8]  = '{1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b11, 32'h33, 32'h33};
    vt[9]  = '{1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0};
    vt[10] = '{1'b1, 32'h44,       1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0};
    vt[11] = '{1'b1, 32'h55,       1'b0, 1'b0, 2'b11, 2'b01, 32'h44, 32'h0};
    vt[12] = '{1'b1, 32'h66,       1'b0, 1'b1, 2'b00, 2'b11, 32'h44, 32'h44};
    vt[13] = '{1'b0, 32'h0,        1'b1, 1'b0, 2'b11, 2'b00, 32'h0, 32'h0};
    vt[14] = '{1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b01, 32'h66, 32'h0};
    vt[15] = '{1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b10, 32'h0, 32'h66};
    vt[16] = '{1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0};

    // Reset with a word already waiting in the afifo
    @(negedge clk);
    push_word(32'hA5A5_0001);
    settle();
    for (int c = 0; c < 2; c++) begin
      chk("reset_ren", c, 32'(ren[c]), 32'd0);
      chk("reset_valid", c, 32'(valid[c]), 32'd0);
      chk("reset_data", c, data[c], 32'd0);
    end
    advance();
    rst_n = 1'b1;
    ready = 1'b1;
    settle();
    for (int c = 0; c < 2; c++) chk("ren_after_release", c, 32'(ren[c]), 32'd1);
    advance();
    repeat (4) begin settle(); advance(); end
    for (int c = 0; c < 2; c++) chk("reset_word_delivered", c, 32'(delivered[c]), 32'd1);

    // Cycle-exact vectors: single word, stall/refill, flush with buffered + in-flight
    for (int i = 0; i < 17; i++) begin
      if (vt[i].push) push_word(vt[i].word);
      ready = vt[i].rdy;
      flush = vt[i].fl;
      settle();
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("vec%0d_ren", i), c, 32'(ren[c]), 32'(vt[i].exp_ren[c]));
        chk($sformatf("vec%0d_valid", i), c, 32'(valid[c]), 32'(vt[i].exp_valid[c]));
        if (vt[i].exp_valid[c])
          chk($sformatf("vec%0d_data", i), c, data[c], (c == 0) ? vt[i].exp_d0 : vt[i].exp_d1);
      end
      advance();
    end
    flush = 1'b0;

    // Streaming 16 words with the consumer always ready
    ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(W'(i));
    for (int c = 0; c < 2; c++) begin base[c] = delivered[c]; beats[c] = 0; end
    for (int cyc = 0; cyc < 40; cyc++) begin
      settle();
      for (int c = 0; c < 2; c++) begin
        if (beats[c] > 0 && beats[c] < 16) chk("stream_no_gap", c, 32'(valid[c]), 32'd1);
        if (s_pop[c]) beats[c]++;
      end
      advance();
    end
    for (int c = 0; c < 2; c++) chk("stream_beats", c, 32'(delivered[c] - base[c]), 32'd16);
`ifdef AFIFO_RD_CNT_EN
    for (int c = 0; c < 2; c++) chk("rd_count_stream", c, rd_count[c], 32'(delivered[c]));
`endif

    // Consumer stall with 8 words queued
    ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(W'(i));
    for (int c = 0; c < 2; c++) begin base[c] = delivered[c]; rbase[c] = ren_cnt[c]; end
    for (int cyc = 0; cyc < 10; cyc++) begin
      settle();
      for (int c = 0; c < 2; c++) if (s_valid[c]) chk("stall_head", c, s_data[c], 32'd0);
      advance();
    end
    for (int c = 0; c < 2; c++) chk("stall_ren_pulses", c, 32'(ren_cnt[c] - rbase[c]), 32'd2);
    ready = 1'b1;
    repeat (20) begin settle(); advance(); end
    for (int c = 0; c < 2; c++) chk("stall_drained", c, 32'(delivered[c] - base[c]), 32'd8);

    // Random producer and consumer, 1000 words
    for (int c = 0; c < 2; c++) base[c] = delivered[c];
    pushed = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (delivered[0] - base[0] >= 1000 && delivered[1] - base[1] >= 1000) break;
      if (pushed < 1000 && ($urandom % 2) == 0) begin
        push_word($urandom);
        pushed++;
      end
      ready = ($urandom % 2) == 0;
      settle();
      advance();
    end
    for (int c = 0; c < 2; c++) chk("random_delivered", c, 32'(delivered[c] - base[c]), 32'd1000);
`ifdef AFIFO_RD_CNT_EN
    for (int c = 0; c < 2; c++) chk("rd_count_final", c, rd_count[c], 32'(delivered[c]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
